// File: rtl/mac_mii_rx.sv
// mac_mii_rx: 64-bit MII receive framer.
//   Finds a start word with its preamble and SFD, then streams every frame byte
//   after the SFD as lane-aligned beats. It checks the CRC-32 residue, captures
//   the Ethernet header fields, and flags preamble, framing, runt and oversize
//   errors.
// Ports:
//   clk, i_rst_n                 clock, async active-low reset
//   i_mii_data / i_mii_valid     MII word (lane 0 first) and per-lane control flags
//   o_data/o_keep/o_valid/o_last output beat stream (1-cycle registered latency)
//   o_dest_address/o_src_address/o_eth_type  captured header fields
//   o_byte_count/o_fcs_ok/o_frame_error/o_frame_done  per-frame status
//   o_preamble_error             one-cycle pulse for a bad preamble or SFD
module mac_mii_rx #(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned CTRL_WIDTH      = 8,
  parameter logic [7:0]  IDLE_CODE       = 8'h07,
  parameter logic [7:0]  START_CODE      = 8'hFB,
  parameter logic [7:0]  TERM_CODE       = 8'hFD,
  parameter logic [7:0]  PREAMBLE_CODE   = 8'h55,
  parameter logic [7:0]  SFD_CODE        = 8'hD5,
  parameter int unsigned MAX_FRAME_BYTES = 1518
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_mii_data,
  input  logic [CTRL_WIDTH-1:0] i_mii_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [CTRL_WIDTH-1:0] o_keep,
  output logic                  o_valid,
  output logic                  o_last,
  output logic [47:0]           o_dest_address,
  output logic [47:0]           o_src_address,
  output logic [15:0]           o_eth_type,
  output logic [15:0]           o_byte_count,
  output logic                  o_frame_done,
  output logic                  o_fcs_ok,
  output logic                  o_preamble_error,
  output logic                  o_frame_error
);

  localparam int unsigned LW        = $clog2(CTRL_WIDTH);
  localparam int unsigned KW        = LW + 1;
  localparam logic [31:0] CRC_POLY  = 32'hEDB88320;
  localparam logic [31:0] CRC_RES   = 32'hDEBB20E3;
  localparam logic [15:0] MAX_BYTES = 16'(MAX_FRAME_BYTES);
  localparam logic [15:0] MIN_BYTES = 16'd64;

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_DROP} state_e;

  state_e                  state_q, state_d;
  logic [31:0]             crc_q, crc_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [CTRL_WIDTH-1:0]   keep_q, keep_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic [47:0]             dest_q, dest_d;
  logic [47:0]             src_q, src_d;
  logic [15:0]             type_q, type_d;
  logic [15:0]             bcount_q, bcount_d;
  logic                    done_q, done_d;
  logic                    fcs_ok_q, fcs_ok_d;
  logic                    perr_q, perr_d;
  logic                    ferr_q, ferr_d;

  logic [7:0]              lane [CTRL_WIDTH];
  logic [KW-1:0]           low_k;
  logic [KW-1:0]           nbytes;
  logic                    is_start, pre_ok, is_term, has_term, all_idle;
  logic [31:0]             crc_nx;
  logic [16:0]             cnt_sum;
  logic [15:0]             cnt_sat;
  logic [15:0]             hdr_pos;
  logic [47:0]             dest_nx, src_nx;
  logic [15:0]             type_nx;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int unsigned i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  // Word decode: lanes, start/preamble and terminate classification.
  always_comb begin
    for (int unsigned j = 0; j < CTRL_WIDTH; j++) begin
      lane[j] = i_mii_data[8*j +: 8];
    end

    low_k = KW'(CTRL_WIDTH);
    for (int unsigned j = CTRL_WIDTH; j > 0; j--) begin
      if (i_mii_valid[j-1]) low_k = KW'(j - 1);
    end

    is_start = (i_mii_valid == CTRL_WIDTH'(1)) && (lane[0] == START_CODE);
    pre_ok   = (lane[CTRL_WIDTH-1] == SFD_CODE);
    for (int unsigned j = 1; j < CTRL_WIDTH - 1; j++) begin
      if (lane[j] != PREAMBLE_CODE) pre_ok = 1'b0;
    end

    // A valid terminate needs every control bit from k upward set and TERM at lane k.
    is_term = (|i_mii_valid)
           && (i_mii_valid == ({CTRL_WIDTH{1'b1}} << low_k))
           && (lane[low_k[LW-1:0]] == TERM_CODE);

    has_term = 1'b0;
    all_idle = &i_mii_valid;
    for (int unsigned j = 0; j < CTRL_WIDTH; j++) begin
      if (i_mii_valid[j] && (lane[j] == TERM_CODE)) has_term = 1'b1;
      if (lane[j] != IDLE_CODE) all_idle = 1'b0;
    end

    nbytes = (i_mii_valid == '0) ? KW'(CTRL_WIDTH) : low_k;
  end

  // Byte accounting, CRC and header capture for the data lanes of this word.
  always_comb begin
    cnt_sum = {1'b0, cnt_q} + 17'(nbytes);
    cnt_sat = cnt_sum[16] ? '1 : cnt_sum[15:0];

    crc_nx  = crc_q;
    dest_nx = dest_q;
    src_nx  = src_q;
    type_nx = type_q;
    hdr_pos = '0;
    for (int unsigned j = 0; j < CTRL_WIDTH; j++) begin
      if (KW'(j) < nbytes) begin
        crc_nx  = crc_byte(crc_nx, lane[j]);
        hdr_pos = cnt_q + 16'(j);
        if (hdr_pos < 16'd6)
          dest_nx[8*(5 - int'(hdr_pos[2:0])) +: 8] = lane[j];
        else if (hdr_pos < 16'd12)
          src_nx[8*(11 - int'(hdr_pos[3:0])) +: 8] = lane[j];
        else if (hdr_pos < 16'd14)
          type_nx[8*(13 - int'(hdr_pos[3:0])) +: 8] = lane[j];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    crc_d    = crc_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    keep_d   = keep_q;
    valid_d  = 1'b0;
    last_d   = 1'b0;
    dest_d   = dest_q;
    src_d    = src_q;
    type_d   = type_q;
    bcount_d = bcount_q;
    done_d   = 1'b0;
    fcs_ok_d = fcs_ok_q;
    perr_d   = 1'b0;
    ferr_d   = ferr_q;

    unique case (state_q)
      ST_DATA: begin
        if (i_mii_valid == '0) begin
          data_d = i_mii_data;
          if (cnt_sat > MAX_BYTES) begin
            valid_d  = 1'b1;
            last_d   = 1'b1;
            keep_d   = '0;
            done_d   = 1'b1;
            bcount_d = cnt_sat;
            fcs_ok_d = 1'b0;
            ferr_d   = 1'b1;
            state_d  = ST_DROP;
          end else begin
            valid_d = 1'b1;
            keep_d  = '1;
            crc_d   = crc_nx;
            cnt_d   = cnt_sat;
            dest_d  = dest_nx;
            src_d   = src_nx;
            type_d  = type_nx;
          end
        end else if (is_term) begin
          valid_d  = 1'b1;
          last_d   = 1'b1;
          data_d   = i_mii_data;
          keep_d   = ~i_mii_valid;
          done_d   = 1'b1;
          crc_d    = crc_nx;
          cnt_d    = cnt_sat;
          dest_d   = dest_nx;
          src_d    = src_nx;
          type_d   = type_nx;
          bcount_d = cnt_sat;
          fcs_ok_d = (crc_nx == CRC_RES);
          ferr_d   = (cnt_sat < MIN_BYTES) || (cnt_sat > MAX_BYTES);
          state_d  = (cnt_sat > MAX_BYTES) ? ST_DROP : ST_IDLE;
        end else begin
          // Abort beat; a start word in this slot also opens the next frame below.
          valid_d  = 1'b1;
          last_d   = 1'b1;
          data_d   = i_mii_data;
          keep_d   = '0;
          done_d   = 1'b1;
          bcount_d = cnt_q;
          fcs_ok_d = 1'b0;
          ferr_d   = 1'b1;
          state_d  = ST_IDLE;
          if (is_start) begin
            if (pre_ok) begin
              state_d = ST_DATA;
              cnt_d   = '0;
              crc_d   = '1;
            end else begin
              perr_d  = 1'b1;
              state_d = ST_DROP;
            end
          end
        end
      end
      ST_DROP: begin
        if (is_start) begin
          if (pre_ok) begin
            state_d = ST_DATA;
            cnt_d   = '0;
            crc_d   = '1;
          end else begin
            perr_d = 1'b1;
          end
        end else if ((|i_mii_valid) && (has_term || all_idle)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        if (is_start) begin
          if (pre_ok) begin
            state_d = ST_DATA;
            cnt_d   = '0;
            crc_d   = '1;
          end else begin
            perr_d  = 1'b1;
            state_d = ST_DROP;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      crc_q    <= '1;
      cnt_q    <= '0;
      data_q   <= '0;
      keep_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      dest_q   <= '0;
      src_q    <= '0;
      type_q   <= '0;
      bcount_q <= '0;
      done_q   <= 1'b0;
      fcs_ok_q <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      crc_q    <= crc_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      keep_q   <= keep_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      dest_q   <= dest_d;
      src_q    <= src_d;
      type_q   <= type_d;
      bcount_q <= bcount_d;
      done_q   <= done_d;
      fcs_ok_q <= fcs_ok_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
    end
  end

  assign o_data           = data_q;
  assign o_keep           = keep_q;
  assign o_valid          = valid_q;
  assign o_last           = last_q;
  assign o_dest_address   = dest_q;
  assign o_src_address    = src_q;
  assign o_eth_type       = type_q;
  assign o_byte_count     = bcount_q;
  assign o_frame_done     = done_q;
  assign o_fcs_ok         = fcs_ok_q;
  assign o_preamble_error = perr_q;
  assign o_frame_error    = ferr_q;

endmodule

// File: tb/tb_mac_mii_rx.sv
// tb_mac_mii_rx: directed bench for mac_mii_rx. Builds Ethernet frames with a
// locally computed FCS, drives them as MII words and checks beats and status.
module tb_mac_mii_rx;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic [63:0] i_mii_data = '0;
  logic [7:0]  i_mii_valid = '0;
  logic [63:0] o_data;
  logic [7:0]  o_keep;
  logic        o_valid, o_last, o_frame_done, o_fcs_ok, o_preamble_error, o_frame_error;
  logic [47:0] o_dest_address, o_src_address;
  logic [15:0] o_eth_type, o_byte_count;

  always #5 clk = ~clk;

  mac_mii_rx #(.MAX_FRAME_BYTES(1518)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_mii_data(i_mii_data), .i_mii_valid(i_mii_valid),
    .o_data(o_data), .o_keep(o_keep), .o_valid(o_valid), .o_last(o_last),
    .o_dest_address(o_dest_address), .o_src_address(o_src_address), .o_eth_type(o_eth_type),
    .o_byte_count(o_byte_count), .o_frame_done(o_frame_done), .o_fcs_ok(o_fcs_ok),
    .o_preamble_error(o_preamble_error), .o_frame_error(o_frame_error)
  );

  localparam logic [63:0] GOOD_START = 64'hD5555555555555FB;
  localparam logic [63:0] BAD_START  = 64'h55555555555555FB;
  localparam logic [63:0] IDLE_WORD  = {8{8'h07}};

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [7:0]  fr [0:255];
  int          fr_len;
  int          beats;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Frame = dest, src, type, payload, FCS; flip >= 0 corrupts that byte after the FCS.
  task automatic build_frame(input int pl, input int flip);
    logic [31:0] c;
    logic [47:0] src;
    src = 48'h123456789ABC;
    for (int i = 0; i < 6; i++) fr[i] = 8'hFF;
    for (int i = 0; i < 6; i++) fr[6+i] = src[8*(5-i) +: 8];
    fr[12] = 8'h08;
    fr[13] = 8'h00;
    for (int i = 0; i < pl; i++) fr[14+i] = 8'(i * 13 + 1);
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 14 + pl; i++) c = crc_upd(c, fr[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) fr[14+pl+i] = c[8*i +: 8];
    fr_len = 18 + pl;
    if (flip >= 0) fr[flip] = fr[flip] ^ 8'h10;
  endtask

  // Inputs change on the falling edge; after the return the outputs reflect this word.
  task automatic drive(input logic [63:0] d, input logic [7:0] c);
    i_mii_data  = d;
    i_mii_valid = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic data_word(input int w);
    logic [63:0] d;
    for (int j = 0; j < 8; j++) d[8*j +: 8] = fr[8*w + j];
    drive(d, 8'h00);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 64'(o_valid), 64'd0);
    chk({tag, "_last"}, 64'(o_last), 64'd0);
    chk({tag, "_data"}, o_data, 64'd0);
    chk({tag, "_keep"}, 64'(o_keep), 64'd0);
    chk({tag, "_dest"}, 64'(o_dest_address), 64'd0);
    chk({tag, "_bcnt"}, 64'(o_byte_count), 64'd0);
    chk({tag, "_done"}, 64'(o_frame_done), 64'd0);
    chk({tag, "_ferr"}, 64'(o_frame_error), 64'd0);
  endtask

  task automatic send_frame(input string tag, input int exp_bc, input logic exp_fcs,
                            input logic exp_ferr);
    logic [63:0] d;
    logic [7:0]  c;
    int          nfull, r;
    drive(GOOD_START, 8'h01);
    chk({tag, "_start_novalid"}, 64'(o_valid), 64'd0);
    beats = 0;
    nfull = fr_len / 8;
    r     = fr_len % 8;
    for (int w = 0; w < nfull; w++) begin
      data_word(w);
      if (o_valid && !o_last) beats++;
    end
    for (int j = 0; j < 8; j++) begin
      if (j < r)       d[8*j +: 8] = fr[8*nfull + j];
      else if (j == r) d[8*j +: 8] = 8'hFD;
      else             d[8*j +: 8] = 8'h07;
    end
    c = 8'hFF << r;
    drive(d, c);
    if (o_valid) beats++;
    chk({tag, "_beats"}, 64'(beats), 64'(nfull + 1));
    chk({tag, "_last"}, 64'(o_last), 64'd1);
    chk({tag, "_lastkeep"}, 64'(o_keep), 64'(8'((1 << r) - 1)));
    chk({tag, "_done"}, 64'(o_frame_done), 64'd1);
    chk({tag, "_bcnt"}, 64'(o_byte_count), 64'(exp_bc));
    chk({tag, "_fcs"}, 64'(o_fcs_ok), 64'(exp_fcs));
    chk({tag, "_ferr"}, 64'(o_frame_error), 64'(exp_ferr));
    drive(IDLE_WORD, 8'hFF);
    chk({tag, "_idle_novalid"}, 64'(o_valid), 64'd0);
    chk({tag, "_done_pulse"}, 64'(o_frame_done), 64'd0);
    chk({tag, "_bcnt_hold"}, 64'(o_byte_count), 64'(exp_bc));
  endtask

  initial begin
    int seen;
    #1 i_rst_n = 1'b0;
    #1 check_zero("reset");
    @(negedge clk);
    i_rst_n = 1'b1;
    drive(IDLE_WORD, 8'hFF);
    chk("idle_novalid", 64'(o_valid), 64'd0);

    // Good frame, 50-byte payload.
    build_frame(50, -1);
    send_frame("good", 68, 1'b1, 1'b0);
    chk("good_keep_hold", 64'(o_keep), 64'h0F);
    chk("good_dest", 64'(o_dest_address), 64'hFFFFFFFFFFFF);
    chk("good_src", 64'(o_src_address), 64'h123456789ABC);
    chk("good_type", 64'(o_eth_type), 64'h0800);

    // Payload byte corrupted.
    build_frame(50, 20);
    send_frame("flip", 68, 1'b0, 1'b0);

    // Minimum frame ending with TERM in lane 0.
    build_frame(46, -1);
    send_frame("min", 64, 1'b1, 1'b0);
    chk("min_keep_zero", 64'(o_keep), 64'h00);

    // Runt frame.
    build_frame(20, -1);
    send_frame("runt", 38, 1'b1, 1'b1);

    // Bad SFD, then data words that must be dropped, then a good frame.
    drive(BAD_START, 8'h01);
    chk("perr_pulse", 64'(o_preamble_error), 64'd1);
    chk("perr_novalid", 64'(o_valid), 64'd0);
    seen = 0;
    build_frame(50, -1);
    for (int w = 0; w < 3; w++) begin
      data_word(w);
      if (o_valid) seen++;
    end
    chk("perr_cleared", 64'(o_preamble_error), 64'd0);
    chk("drop_novalid", 64'(seen), 64'd0);
    send_frame("after_perr", 68, 1'b1, 1'b0);

    // Frame cut by an idle word.
    drive(GOOD_START, 8'h01);
    for (int w = 0; w < 3; w++) data_word(w);
    drive(IDLE_WORD, 8'hFF);
    chk("cut_valid", 64'(o_valid), 64'd1);
    chk("cut_last", 64'(o_last), 64'd1);
    chk("cut_keep", 64'(o_keep), 64'h00);
    chk("cut_ferr", 64'(o_frame_error), 64'd1);
    chk("cut_done", 64'(o_frame_done), 64'd1);
    send_frame("after_cut", 68, 1'b1, 1'b0);

    // Reset in the middle of a frame.
    drive(GOOD_START, 8'h01);
    for (int w = 0; w < 3; w++) data_word(w);
    chk("rst_beat3_valid", 64'(o_valid), 64'd1);
    i_rst_n = 1'b0;
    #1 check_zero("midrst");
    @(negedge clk);
    i_rst_n = 1'b1;
    seen = 0;
    for (int w = 3; w < 8; w++) begin
      data_word(w);
      if (o_valid || o_last) seen++;
    end
    drive({8'h07, 8'h07, 8'h07, 8'hFD, fr[67], fr[66], fr[65], fr[64]}, 8'hF0);
    if (o_valid || o_last) seen++;
    chk("midrst_no_output", 64'(seen), 64'd0);
    send_frame("after_rst", 68, 1'b1, 1'b0);
    chk("after_rst_src", 64'(o_src_address), 64'h123456789ABC);

    // Oversize: the 190th data word takes the count to 1520 > 1518.
    drive(GOOD_START, 8'h01);
    beats = 0;
    for (int w = 0; w < 190; w++) begin
      drive({8{8'(w)}}, 8'h00);
      if (o_valid && !o_last) beats++;
    end
    chk("over_beats", 64'(beats), 64'd189);
    chk("over_last", 64'(o_last), 64'd1);
    chk("over_ferr", 64'(o_frame_error), 64'd1);
    chk("over_done", 64'(o_frame_done), 64'd1);
    seen = 0;
    for (int w = 0; w < 2; w++) begin
      drive(64'h0123456789ABCDEF, 8'h00);
      if (o_valid) seen++;
    end
    drive({8'h07, 8'h07, 8'h07, 8'hFD, 32'h11223344}, 8'hF0);
    if (o_valid) seen++;
    chk("over_drop_novalid", 64'(seen), 64'd0);
    build_frame(50, -1);
    send_frame("after_over", 68, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
